// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Time-multiplexes two hex digits onto one shared seven-segment
//            display: high digit, gap, low digit, long gap, repeat.
//            Optional macro SEG7_LZ_SUPPRESS_EN skips a leading zero digit.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 250,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       digit_sel,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHOW_HI = 3'd1,
    GAP     = 3'd2,
    SHOW_LO = 3'd3,
    LGAP    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LGAP_LAST  = CNT_W'(2 * GAP_CYCLES - 1);
  localparam bit               HAS_GAP    = (GAP_CYCLES != 0);

  state_t           state, state_nx;
  logic [7:0]       held, held_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [3:0]       nibble_nx;
  logic             blank_nx, sel_nx, busy_nx, done_nx;
  logic             last;
  logic             skip_new, skip_held;
  state_t           start_new, start_held;

  // Leading-zero suppression enters the pass at the low digit.
`ifdef SEG7_LZ_SUPPRESS_EN
  assign skip_new  = (value[7:4] == 4'h0);
  assign skip_held = (held[7:4] == 4'h0);
`else
  assign skip_new  = 1'b0;
  assign skip_held = 1'b0;
`endif

  assign start_new  = skip_new  ? SHOW_LO : SHOW_HI;
  assign start_held = skip_held ? SHOW_LO : SHOW_HI;

  always_comb begin
    case (state)
      SHOW_HI, SHOW_LO: last = (count == DWELL_LAST);
      GAP:              last = (count == GAP_LAST);
      LGAP:             last = (count == LGAP_LAST);
      default:          last = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    held_nx  = held;
    count_nx = count + CNT_W'(1);
    done_nx  = 1'b0;
    if (load) begin
      held_nx  = value;
      state_nx = start_new;
      count_nx = '0;
    end else begin
      case (state)
        IDLE: count_nx = '0;
        SHOW_HI: if (last) begin
          state_nx = HAS_GAP ? GAP : SHOW_LO;
          count_nx = '0;
        end
        GAP: if (last) begin
          state_nx = SHOW_LO;
          count_nx = '0;
        end
        SHOW_LO: if (last) begin
          count_nx = '0;
          if (HAS_GAP) begin
            state_nx = LGAP;
          end else begin
            state_nx = start_held;
            done_nx  = 1'b1;
          end
        end
        LGAP: if (last) begin
          state_nx = start_held;
          count_nx = '0;
          done_nx  = 1'b1;
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
        end
      endcase
    end

    // Outputs are registered from the next state; nibble holds through gaps.
    nibble_nx = nibble;
    blank_nx  = 1'b1;
    sel_nx    = 1'b0;
    busy_nx   = (state_nx != IDLE);
    case (state_nx)
      SHOW_HI: begin
        nibble_nx = held_nx[7:4];
        blank_nx  = 1'b0;
        sel_nx    = 1'b1;
      end
      SHOW_LO: begin
        nibble_nx = held_nx[3:0];
        blank_nx  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      held      <= 8'h00;
      count     <= '0;
      nibble    <= 4'h0;
      blank     <= 1'b1;
      digit_sel <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      held      <= held_nx;
      count     <= count_nx;
      nibble    <= nibble_nx;
      blank     <= blank_nx;
      digit_sel <= sel_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Self-checking bench; a gapped and a gapless instance share stimulus
//            and are compared every cycle against a pass-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int DW = 4;
`ifdef SEG7_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] value = 8'h00;
  logic [3:0] nib_a, nib_b;
  logic       blank_a, blank_b, sel_a, sel_b, busy_a, busy_b, done_a, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: idle flag, held value, cycles since last load.
  bit         m_idle = 1'b1;
  logic [7:0] m_held = 8'h00;
  int         m_t    = 0;

  int         gap_of [2] = '{2, 0};
  logic [7:0] obs [2];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DWELL_CYCLES(DW), .GAP_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .nibble(nib_a), .blank(blank_a), .digit_sel(sel_a), .busy(busy_a), .done(done_a)
  );

  seg7_scan_ctrl #(.DWELL_CYCLES(DW), .GAP_CYCLES(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .nibble(nib_b), .blank(blank_b), .digit_sel(sel_b), .busy(busy_b), .done(done_b)
  );

  assign obs[0] = {nib_a, blank_a, sel_a, busy_a, done_a};
  assign obs[1] = {nib_b, blank_b, sel_b, busy_b, done_b};

  // Expected {nibble, blank, digit_sel, busy, done} from the pass layout.
  function automatic logic [7:0] exp_vec(input int gap);
    int hi, g1, lo, g2, p;
    bit skip, dn;
    if (m_idle) return {4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    skip = LZ && (m_held[7:4] == 4'h0);
    hi = skip ? 0 : DW;
    g1 = skip ? 0 : gap;
    lo = DW;
    g2 = 2 * gap;
    p  = m_t % (hi + g1 + lo + g2);
    dn = (m_t >= hi + g1 + lo + g2) && (p == 0);
    if (p < hi)                return {m_held[7:4], 1'b0, 1'b1, 1'b1, dn};
    else if (p < hi + g1)      return {m_held[7:4], 1'b1, 1'b0, 1'b1, dn};
    else if (p < hi + g1 + lo) return {m_held[3:0], 1'b0, 1'b0, 1'b1, dn};
    else                       return {m_held[3:0], 1'b1, 1'b0, 1'b1, dn};
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_idle = 1'b1;
      m_t    = 0;
    end else if (load) begin
      m_idle = 1'b0;
      m_held = value;
      m_t    = 0;
    end else if (!m_idle) begin
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; value = 8'h00;
    repeat (3) tick();
    reset = 1'b0; load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== {4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL reset_idle dut%0d cyc%0d got %h expected %h", d, c, obs[d], 8'h08);
        end
      end
      tick();
    end
  endtask

  task automatic test_sequence(input logic [7:0] v, input int cycles);
    value = v; load = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++;
    if (!(LZ && v[7:4] == 4'h0) && (nib_a !== v[7:4] || sel_a !== 1'b1 || blank_a !== 1'b0)) begin
      n_bad++;
      $display("FAIL first_digit got nib=%h sel=%b blank=%b expected nib=%h sel=1 blank=0",
               nib_a, sel_a, blank_a, v[7:4]);
    end
    for (int c = 0; c < cycles; c++) begin
      value = 8'($urandom);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_vec(gap_of[d])) begin
          n_bad++;
          $display("FAIL seq_%h dut%0d t=%0d got %h expected %h", v, d, m_t, obs[d], exp_vec(gap_of[d]));
        end
      end
      tick();
    end
  endtask

  task automatic test_restart();
    value = 8'h3C; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (7) tick();
    value = 8'hA5; load = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++;
    if (nib_a !== 4'hA || done_a !== 1'b0 || sel_a !== 1'b1) begin
      n_bad++;
      $display("FAIL restart got nib=%h done=%b sel=%b expected nib=a done=0 sel=1", nib_a, done_a, sel_a);
    end
    for (int c = 0; c < 20; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_vec(gap_of[d])) begin
          n_bad++;
          $display("FAIL restart dut%0d t=%0d got %h expected %h", d, m_t, obs[d], exp_vec(gap_of[d]));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_lgap();
    value = 8'h3C; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs[d] !== {4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL mid_reset dut%0d got %h expected %h", d, obs[d], 8'h08);
      end
    end
    tick();
    test_sequence(8'h70, 30);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 15) == 0) || (c >= 300 && c < 306);
      value = ($urandom_range(0, 3) == 0) ? {4'h0, 4'($urandom)} : 8'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_vec(gap_of[d])) begin
          n_bad++;
          $display("FAIL random dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_vec(gap_of[d]));
        end
      end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence(8'h3C, 40);
    test_restart();
    test_sequence(8'h91, 24);
    test_sequence(8'h07, 24);
    test_sequence(8'h00, 16);
    test_reset_mid_lgap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
